dcache_axi_mem_model: RTL and testbench

- Parametrised AXI-style slave memory model for the DRAM-cache testbench. Each index stores one metadata word (valid/dirty/tag) and one data line.
- Adds over the previous model:
  - configurable geometry;
  - programmable read and write latency;
  - ID echo on R and B;
  - per-index valid tracking, so unwritten lines read as zero;
  - defined same-cycle read/write collision behaviour.
- Sits behind the DRAM-cache controller's memory-side port in simulation.

---
 rtl/dcache_axi_mem_model_if.sv | 41 ++++
 rtl/dcache_axi_mem_model.sv | 154 +++++++++++++++
 tb/tb_dcache_axi_mem_model.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/dcache_axi_mem_model_if.sv
// AXI-style bus bundle between the DRAM-cache memory-side port and the memory model.
// master: the cache controller / testbench side.
// slave:  the memory model side.
// Channels: AR (arid/araddr/arvalid/arready), R (rid/rdata/rvalid/rready),
//           AW (awid/awaddr/awvalid/awready), W (wdata/wvalid/wready),
//           B (bid/bvalid/bready). rdata carries {metadata, line}.
interface dcache_axi_mem_model_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 512,
  parameter int ID_W   = 16,
  parameter int META_W = 64
);
  logic [ID_W-1:0]          arid;
  logic [ADDR_W-1:0]        araddr;
  logic                     arvalid;
  logic                     arready;
  logic [ID_W-1:0]          rid;
  logic [META_W+DATA_W-1:0] rdata;
  logic                     rvalid;
  logic                     rready;
  logic [ID_W-1:0]          awid;
  logic [ADDR_W-1:0]        awaddr;
  logic                     awvalid;
  logic                     awready;
  logic [DATA_W-1:0]        wdata;
  logic                     wvalid;
  logic                     wready;
  logic [ID_W-1:0]          bid;
  logic                     bvalid;
  logic                     bready;

  modport master (
    output arid, araddr, arvalid, rready, awid, awaddr, awvalid, wdata, wvalid, bready,
    input  arready, rid, rdata, rvalid, awready, wready, bid, bvalid
  );

  modport slave (
    input  arid, araddr, arvalid, rready, awid, awaddr, awvalid, wdata, wvalid, bready,
    output arready, rid, rdata, rvalid, awready, wready, bid, bvalid
  );
endinterface

// File: rtl/dcache_axi_mem_model.sv
// Simulation memory model behind the DRAM-cache memory-side port.
// Each index holds one metadata word {valid, dirty, tag, 0...} and one data line.
// Ports: clk, rst_n (synchronous, active-low), bus (slave modport of
// dcache_axi_mem_model_if). One outstanding transaction per channel; the read
// and write FSMs are independent. Programmable latencies: rvalid RD_LAT+1
// cycles after the AR handshake cycle, bvalid WR_LAT+1 cycles after the W
// handshake cycle. Unwritten (or reset-invalidated) lines read as zero. A read
// sampling the index a write commits on the same edge sees the new contents.
module dcache_axi_mem_model #(
  parameter int ADDR_W   = 64,
  parameter int DATA_W   = 512,
  parameter int ID_W     = 16,
  parameter int META_W   = 64,
  parameter int INDEX_W  = 10,
  parameter int OFFSET_W = 6,
  parameter int RD_LAT   = 4,
  parameter int WR_LAT   = 2
) (
  input logic                   clk,
  input logic                   rst_n,
  dcache_axi_mem_model_if.slave bus
);
  localparam int DEPTH  = 1 << INDEX_W;
  localparam int TAG_W  = ADDR_W - INDEX_W - OFFSET_W;
  localparam int LINE_W = META_W + DATA_W;
  localparam logic [15:0] RD_LOAD = 16'(RD_LAT - 1);
  localparam logic [15:0] WR_LOAD = 16'(WR_LAT - 1);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_WAIT, W_RESP} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_e;

  logic [META_W-1:0] meta_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [DEPTH-1:0]  valid_q;

  w_state_e          w_state, w_next;
  logic [15:0]       w_cnt;
  logic [ID_W-1:0]   aw_id_q;
  logic [INDEX_W-1:0] aw_idx_q;
  logic [META_W-1:0] aw_meta_q, aw_meta_d;
  logic [DATA_W-1:0] wdata_q;

  r_state_e          r_state, r_next;
  logic [15:0]       r_cnt;
  logic [ID_W-1:0]   ar_id_q;
  logic [INDEX_W-1:0] ar_idx_q;
  logic [LINE_W-1:0] rdata_q, rd_line;

  logic aw_hs, w_hs, ar_hs, w_commit, r_sample;

  assign aw_hs = bus.awvalid && bus.awready;
  assign w_hs  = bus.wvalid && bus.wready;
  assign ar_hs = bus.arvalid && bus.arready;
  // Gated by rst_n so a write caught in W_WAIT by reset is dropped, never committed.
  assign w_commit = rst_n && (w_state == W_WAIT) && (w_cnt == '0);
  assign r_sample = rst_n && (r_state == R_WAIT) && (r_cnt == '0);

  assign bus.bid   = aw_id_q;
  assign bus.rid   = ar_id_q;
  assign bus.rdata = rdata_q;

  always_comb begin
    aw_meta_d = '0;
    aw_meta_d[META_W-1] = 1'b1;
    aw_meta_d[META_W-2] = bus.awaddr[ADDR_W-1];
    aw_meta_d[META_W-3 -: TAG_W] = bus.awaddr[ADDR_W-1 -: TAG_W];
  end

  // ---------------- write channel ----------------
  always_comb begin
    w_next      = w_state;
    bus.awready = 1'b0;
    bus.wready  = 1'b0;
    bus.bvalid  = 1'b0;
    case (w_state)
      W_IDLE: begin bus.awready = rst_n; if (bus.awvalid) w_next = W_DATA; end
      W_DATA: begin bus.wready = rst_n; if (bus.wvalid) w_next = W_WAIT; end
      W_WAIT: if (w_cnt == '0) w_next = W_RESP;
      W_RESP: begin bus.bvalid = 1'b1; if (bus.bready) w_next = W_IDLE; end
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      w_state <= W_IDLE;
      w_cnt   <= '0;
      aw_id_q <= '0;
      valid_q <= '0;
    end else begin
      w_state <= w_next;
      if (aw_hs) aw_id_q <= bus.awid;
      if (w_hs) w_cnt <= WR_LOAD;
      else if (w_state == W_WAIT && w_cnt != '0) w_cnt <= w_cnt - 16'd1;
      if (w_commit) valid_q[aw_idx_q] <= 1'b1;
    end
  end

  // Datapath and storage need no reset; stale contents are masked by valid_q.
  always_ff @(posedge clk) begin
    if (aw_hs) begin
      aw_idx_q  <= bus.awaddr[INDEX_W+OFFSET_W-1:OFFSET_W];
      aw_meta_q <= aw_meta_d;
    end
    if (w_hs) wdata_q <= bus.wdata;
    if (w_commit) begin
      meta_mem[aw_idx_q] <= aw_meta_q;
      data_mem[aw_idx_q] <= wdata_q;
    end
    if (ar_hs) ar_idx_q <= bus.araddr[INDEX_W+OFFSET_W-1:OFFSET_W];
  end

  // ---------------- read channel ----------------
  always_comb begin
    r_next      = r_state;
    bus.arready = 1'b0;
    bus.rvalid  = 1'b0;
    case (r_state)
      R_IDLE: begin bus.arready = rst_n; if (bus.arvalid) r_next = R_WAIT; end
      R_WAIT: if (r_cnt == '0) r_next = R_DATA;
      R_DATA: begin bus.rvalid = 1'b1; if (bus.rready) r_next = R_IDLE; end
      default: r_next = R_IDLE;
    endcase
  end

  // Write-first bypass: a commit landing on the sample edge wins over the array.
  always_comb begin
    if (w_commit && aw_idx_q == ar_idx_q) rd_line = {aw_meta_q, wdata_q};
    else if (valid_q[ar_idx_q])           rd_line = {meta_mem[ar_idx_q], data_mem[ar_idx_q]};
    else                                  rd_line = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= R_IDLE;
      r_cnt   <= '0;
      ar_id_q <= '0;
      rdata_q <= '0;
    end else begin
      r_state <= r_next;
      if (ar_hs) begin
        ar_id_q <= bus.arid;
        r_cnt   <= RD_LOAD;
      end else if (r_state == R_WAIT && r_cnt != '0) begin
        r_cnt <= r_cnt - 16'd1;
      end
      if (r_sample) rdata_q <= rd_line;
    end
  end

  logic unused_addr;
  assign unused_addr = ^{bus.araddr[ADDR_W-1:INDEX_W+OFFSET_W], bus.araddr[OFFSET_W-1:0],
                         bus.awaddr[OFFSET_W-1:0]};
endmodule

// File: tb/tb_dcache_axi_mem_model.sv
// Directed bench for dcache_axi_mem_model (default geometry, RD_LAT=4, WR_LAT=2).
// Inputs change and outputs are sampled 1 ns after the rising edge.
module tb_dcache_axi_mem_model;
  typedef logic [575:0] line_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  dcache_axi_mem_model_if #(.ADDR_W(64), .DATA_W(512), .ID_W(16), .META_W(64)) bus ();

  dcache_axi_mem_model #(
    .ADDR_W(64), .DATA_W(512), .ID_W(16), .META_W(64),
    .INDEX_W(10), .OFFSET_W(6), .RD_LAT(4), .WR_LAT(2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  task automatic chk(input string tag, input line_t got, input line_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full write; exp_lat counts cycles from the W handshake cycle to first bvalid.
  task automatic do_write(input logic [63:0] a, input logic [15:0] id, input logic [511:0] d,
                          input int hold, input int exp_lat);
    int n;
    bus.awaddr = a; bus.awid = id; bus.awvalid = 1'b1;
    n = 0;
    while (!bus.awready && n < 50) begin step(); n++; end
    chk("awready", line_t'(bus.awready), line_t'(1));
    step();
    bus.awvalid = 1'b0; bus.wdata = d; bus.wvalid = 1'b1;
    n = 0;
    while (!bus.wready && n < 50) begin step(); n++; end
    chk("wready", line_t'(bus.wready), line_t'(1));
    step();
    bus.wvalid = 1'b0;
    n = 1;
    while (!bus.bvalid && n < 50) begin step(); n++; end
    chk("b_lat", line_t'(n), line_t'(exp_lat));
    chk("bid", line_t'(bus.bid), line_t'(id));
    for (int i = 0; i < hold; i++) begin
      step();
      chk("b_hold", line_t'({bus.bvalid, bus.awready, bus.bid}), line_t'({1'b1, 1'b0, id}));
    end
    bus.bready = 1'b1;
    step();
    bus.bready = 1'b0;
    chk("aw_next", line_t'({bus.bvalid, bus.awready}), line_t'(2'b01));
  endtask

  task automatic do_read(input logic [63:0] a, input logic [15:0] id, input line_t exp,
                         input int hold, input int exp_lat);
    int n;
    bus.araddr = a; bus.arid = id; bus.arvalid = 1'b1;
    n = 0;
    while (!bus.arready && n < 50) begin step(); n++; end
    chk("arready", line_t'(bus.arready), line_t'(1));
    step();
    bus.arvalid = 1'b0;
    n = 1;
    while (!bus.rvalid && n < 50) begin step(); n++; end
    chk("r_lat", line_t'(n), line_t'(exp_lat));
    chk("rid", line_t'(bus.rid), line_t'(id));
    chk("rdata", bus.rdata, exp);
    for (int i = 0; i < hold; i++) begin
      step();
      chk("r_hold", line_t'({bus.rvalid, bus.arready, bus.rid}), line_t'({1'b1, 1'b0, id}));
      chk("r_hold_data", bus.rdata, exp);
    end
    bus.rready = 1'b1;
    step();
    bus.rready = 1'b0;
    chk("ar_next", line_t'({bus.rvalid, bus.arready}), line_t'(2'b01));
  endtask

  initial begin
    rst_n = 1'b0;
    bus.arid = '0; bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
    bus.awid = '0; bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0;
    bus.wvalid = 1'b0; bus.bready = 1'b0;
    step(); step();

    // Reset state: all handshake outputs low, echoes and data cleared.
    chk("rst_ctrl", line_t'({bus.arready, bus.awready, bus.wready, bus.rvalid, bus.bvalid}),
        line_t'(5'b0));
    chk("rst_ids", line_t'({bus.rid, bus.bid}), line_t'(32'h0));
    chk("rst_rdata", bus.rdata, line_t'(0));
    rst_n = 1'b1;
    #1;
    chk("idle_ready", line_t'({bus.arready, bus.awready}), line_t'(2'b11));

    // 1: index 1, clean, tag 0.
    do_write(64'h0000_0000_0000_0040, 16'd3, {64{8'hA5}}, 0, 3);
    do_read(64'h0000_0000_0000_0040, 16'd7, {2'b10, 48'h0, 14'h0, {64{8'hA5}}}, 0, 5);

    // 2 + 4: index 5, dirty, tag = awaddr[63:16]; responses held off 6 cycles.
    do_write(64'h8123_4567_89AB_0140, 16'hBEEF, {16{32'hDEAD_BEEF}}, 6, 3);
    do_read(64'h8123_4567_89AB_0140, 16'h1234,
            {2'b11, 48'h8123_4567_89AB, 14'h0, {16{32'hDEAD_BEEF}}}, 6, 5);

    // 3: never-written index 9.
    do_read(64'h0000_0000_0000_0240, 16'd2, line_t'(0), 0, 5);

    // 5: write commit and read sample on the same edge, index 20.
    do_write(64'h0000_0000_0000_0500, 16'd4, {64{8'h11}}, 0, 3);
    bus.awaddr = 64'h500; bus.awid = 16'd5; bus.awvalid = 1'b1;
    step();                                  // AW handshake
    bus.awvalid = 1'b0;
    bus.araddr = 64'h500; bus.arid = 16'd6; bus.arvalid = 1'b1;
    step();                                  // AR handshake: sample 4 edges later
    bus.arvalid = 1'b0;
    step();
    bus.wdata = {64{8'h22}}; bus.wvalid = 1'b1;
    step();                                  // W handshake: commit 2 edges later
    bus.wvalid = 1'b0;
    step();
    chk("col_early", line_t'({bus.rvalid, bus.bvalid}), line_t'(2'b00));
    step();
    chk("col_valid", line_t'({bus.rvalid, bus.bvalid}), line_t'(2'b11));
    chk("col_ids", line_t'({bus.rid, bus.bid}), line_t'({16'd6, 16'd5}));
    chk("col_rdata", bus.rdata, {2'b10, 48'h0, 14'h0, {64{8'h22}}});
    bus.rready = 1'b1; bus.bready = 1'b1;
    step();
    bus.rready = 1'b0; bus.bready = 1'b0;

    // 6: reset while the write to index 12 is in W_WAIT.
    bus.awaddr = 64'h300; bus.awid = 16'd9; bus.awvalid = 1'b1;
    step();
    bus.awvalid = 1'b0; bus.wdata = {64{8'h5A}}; bus.wvalid = 1'b1;
    step();
    bus.wvalid = 1'b0;
    rst_n = 1'b0;
    step();
    chk("rst_mid", line_t'({bus.arready, bus.awready, bus.bvalid}), line_t'(3'b000));
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("abort_nob", line_t'({bus.bvalid, bus.awready}), line_t'(2'b01));
    end
    do_read(64'h0000_0000_0000_0300, 16'd10, line_t'(0), 0, 5);
    do_read(64'h0000_0000_0000_0040, 16'd11, line_t'(0), 0, 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
